// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one command byte with odd parity and checks the device ACK.
// Optional PS2_TX_GLITCH_FILTER_EN adds a 3-sample majority-free agreement filter on the synchronised PS2_CLK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 12000,
    parameter int unsigned TIMEOUT_CYC = 1500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_BITS,
        S_ACK,
        S_WAITREL
    } state_t;

    state_t            state;
    logic [9:0]        shift;
    logic [3:0]        bit_cnt;
    logic [INH_W-1:0]  inh_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [1:0]        clk_sync;
    logic [1:0]        data_sync;
    logic              clk_s;
    logic              data_s;
    logic              clk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [1:0] clk_hist;
    logic       clk_filt;

    // clk_s plus the two history bits form the 3-sample window; the filtered level moves only when all agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_hist <= '1;
            clk_filt <= 1'b1;
        end else begin
            clk_hist <= {clk_hist[0], clk_s};
            if (clk_s && (&clk_hist))
                clk_filt <= 1'b1;
            else if (!clk_s && !(|clk_hist))
                clk_filt <= 1'b0;
        end
    end

    assign clk_fall = clk_filt & ~clk_s & ~(|clk_hist);
`else
    logic clk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clk_prev <= 1'b1;
        else
            clk_prev <= clk_s;
    end

    assign clk_fall = clk_prev & ~clk_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            err_code    <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shift      <= {1'b1, ~^tx_data, tx_data};
                        err_code   <= '0;
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    // Accept cycle already drives CLK low, so ending here keeps CLK low for exactly INHIBIT_CYC.
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == INH_W'(INHIBIT_CYC - 2)) begin
                        ps2_data_oe <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    ps2_clk_oe <= 1'b0;
                    to_cnt     <= '0;
                    bit_cnt    <= '0;
                    state      <= S_BITS;
                end
                default: begin
                    if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        err_code    <= 2'd1;
                        tx_ready    <= 1'b1;
                        tx_busy     <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        case (state)
                            S_BITS: begin
                                if (clk_fall) begin
                                    ps2_data_oe <= ~shift[bit_cnt];
                                    bit_cnt     <= bit_cnt + 1'b1;
                                    if (bit_cnt == 4'd9)
                                        state <= S_ACK;
                                end
                            end
                            S_ACK: begin
                                if (clk_fall) begin
                                    if (!data_s) begin
                                        state <= S_WAITREL;
                                    end else begin
                                        ps2_clk_oe  <= 1'b0;
                                        ps2_data_oe <= 1'b0;
                                        tx_err      <= 1'b1;
                                        err_code    <= 2'd2;
                                        tx_ready    <= 1'b1;
                                        tx_busy     <= 1'b0;
                                        state       <= S_IDLE;
                                    end
                                end
                            end
                            S_WAITREL: begin
                                if (clk_s && data_s) begin
                                    tx_done  <= 1'b1;
                                    tx_ready <= 1'b1;
                                    tx_busy  <= 1'b0;
                                    state    <= S_IDLE;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model; device clock is scaled to 100 clk per period.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic [1:0] err_code;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;

    assign ps2_clk_in  = ~ps2_clk_oe & ~dev_clk_low & ~glitch_low;
    assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYC(200), .TIMEOUT_CYC(20000)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
        .err_code(err_code), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_frame_q[$];
    logic [3:0]  exp_res_q[$];
    logic [3:0]  obs_res_q[$];
    int   cyc = 0, inh_cnt = 0, inh_len = 0, rel_cyc = 0, res_cyc = 0;
    logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0, data_at_rel = 1'b0, both_seen = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (ps2_clk_oe === 1'b1) begin
            if (!prev_clk_oe) inh_cnt = 1;
            else inh_cnt++;
        end else if (prev_clk_oe) begin
            rel_cyc     = cyc;
            inh_len     = inh_cnt;
            data_at_rel = prev_data_oe;
        end
        if (tx_done === 1'b1 || tx_err === 1'b1) begin
            obs_res_q.push_back({tx_done, tx_err, err_code});
            res_cyc = cyc;
        end
        if (tx_done === 1'b1 && tx_err === 1'b1) both_seen = 1'b1;
        prev_clk_oe  = (ps2_clk_oe === 1'b1);
        prev_data_oe = (ps2_data_oe === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit hold_valid);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        check("accept_busy", {31'd0, tx_busy}, 1);
        check("accept_code_clear", {30'd0, err_code}, 0);
        if (hold_valid) tx_data = 8'h00;
        else tx_valid = 1'b0;
    endtask

    task automatic device_frame(input int abort_at, input bit do_ack, input int glitch_at,
                                output logic [10:0] bits);
        int n;
        bits = '0;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("dev_inhibit_seen", {31'd0, n < 2000}, 1);
        n = 0;
        while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && n < 2000) begin @(negedge clk); n++; end
        check("dev_request_seen", {31'd0, n < 2000}, 1);
        repeat (HALF) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && do_ack) begin
                dev_data_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i == abort_at) return;
            if (i <= 10) bits[i] = ps2_data_in;
            if (i == glitch_at) begin
                repeat (20) @(negedge clk);
                glitch_low = 1'b1;
                repeat (2) @(negedge clk);
                glitch_low = 1'b0;
                repeat (HALF - 22) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_data_low = 1'b0;
    endtask

    task automatic get_result(input string tag, input int budget);
        int n;
        logic [3:0] e;
        n = 0;
        while (obs_res_q.size() == 0 && n < budget) begin @(negedge clk); n++; end
        e = exp_res_q.pop_front();
        check({tag, "_arrived"}, {31'd0, obs_res_q.size() != 0}, 1);
        if (obs_res_q.size() != 0) check(tag, {28'd0, obs_res_q.pop_front()}, {28'd0, e});
    endtask

    task automatic frame_check(input string tag, input logic [10:0] bits);
        check(tag, {21'd0, bits}, {21'd0, exp_frame_q.pop_front()});
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_frame_q.push_back({1'b1, ~^d, d, 1'b0});
    endtask

    initial begin
        logic [10:0] bits;
        logic [3:0]  r;

        repeat (3) @(negedge clk);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 0);
        check("rst_ready", {31'd0, tx_ready}, 1);
        check("rst_busy", {31'd0, tx_busy}, 0);
        check("rst_done_err", {30'd0, tx_done, tx_err}, 0);
        check("rst_code", {30'd0, err_code}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED, normal ACK
        push_frame(8'hED); exp_res_q.push_back(4'b1000);
        send(8'hED, 1'b0);
        device_frame(99, 1'b1, 0, bits);
        frame_check("frame_ED", bits);
        check("inhibit_len", inh_len, 200);
        check("start_before_release", {31'd0, data_at_rel}, 1);
        get_result("result_ED", 200);
        repeat (20) @(negedge clk);
        check("single_pulse_ED", obs_res_q.size(), 0);
        check("ready_after_ED", {31'd0, tx_ready}, 1);

        // 0xF4, parity 0
        push_frame(8'hF4); exp_res_q.push_back(4'b1000);
        send(8'hF4, 1'b0);
        device_frame(99, 1'b1, 0, bits);
        frame_check("frame_F4", bits);
        get_result("result_F4", 200);

        // device never clocks -> timeout
        exp_res_q.push_back(4'b0101);
        send(8'h55, 1'b0);
        get_result("result_timeout", 25000);
        check("timeout_latency", res_cyc - rel_cyc, 20000);
        @(negedge clk);
        check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);

        // device leaves DATA high at fall 11 -> NACK; code held until next accept
        push_frame(8'hA5); exp_res_q.push_back(4'b0110);
        send(8'hA5, 1'b0);
        device_frame(99, 1'b0, 0, bits);
        frame_check("frame_A5", bits);
        get_result("result_nack", 200);
        repeat (50) @(negedge clk);
        check("nack_code_held", {30'd0, err_code}, 2);
        check("nack_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);

        // tx_valid held with 0x00 during an 0xED frame
        push_frame(8'hED); exp_res_q.push_back(4'b1000);
        send(8'hED, 1'b1);
        device_frame(99, 1'b1, 0, bits);
        tx_valid = 1'b0;
        frame_check("frame_ED_busy_valid", bits);
        get_result("result_ED_busy_valid", 200);
        repeat (20) @(negedge clk);
        check("no_extra_accept", {31'd0, tx_busy}, 0);

        // reset after fall 4, then 0xF3
        send(8'h12, 1'b0);
        device_frame(4, 1'b1, 0, bits);
        #3 rst_n = 1'b0;
        #1 check("midrst_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ready", {31'd0, tx_ready}, 1);
        check("midrst_busy", {31'd0, tx_busy}, 0);
        check("midrst_no_result", obs_res_q.size(), 0);
        repeat (5) @(negedge clk);
        push_frame(8'hF3); exp_res_q.push_back(4'b1000);
        send(8'hF3, 1'b0);
        device_frame(99, 1'b1, 0, bits);
        frame_check("frame_F3", bits);
        get_result("result_F3", 200);

        // 2-cycle low glitch on PS2_CLK after fall 4
`ifdef PS2_TX_GLITCH_FILTER_EN
        push_frame(8'h3C); exp_res_q.push_back(4'b1000);
        send(8'h3C, 1'b0);
        device_frame(99, 1'b1, 4, bits);
        frame_check("frame_glitch", bits);
        get_result("result_glitch", 200);
`else
        send(8'h3C, 1'b0);
        device_frame(99, 1'b1, 4, bits);
        begin
            int n;
            n = 0;
            while (obs_res_q.size() == 0 && n < 25000) begin @(negedge clk); n++; end
            check("glitch_result_arrived", {31'd0, obs_res_q.size() != 0}, 1);
            if (obs_res_q.size() != 0) begin
                r = obs_res_q.pop_front();
                check("glitch_err_flag", {30'd0, r[3:2]}, 1);
                check("glitch_err_code_known", {31'd0, (r[1:0] == 2'd1) || (r[1:0] == 2'd2)}, 1);
            end
        end
`endif

        repeat (20) @(negedge clk);
        check("done_err_exclusive", {31'd0, both_seen}, 0);
        check("no_stray_results", obs_res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
